// File: rtl/scaler_frame_ctrl.sv
// Frame-synchronous front end for scaler_h/scaler_v: gates the stream to whole frames,
// applies scale-step updates only at frame start, and measures input geometry.
module scaler_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP       = 4096,
    parameter int STEP_MAX   = 16383,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cfg_step_i,
    input  logic                  cfg_wr_i,
    output logic                  cfg_pend_o,
    output logic                  cfg_err_o,
    input  logic                  err_clr_i,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [15:0]           scale_step_o,
    output logic [CNT_WIDTH-1:0]  in_w_o,
    output logic [CNT_WIDTH-1:0]  in_h_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o,
    output logic                  line_err_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [15:0]          STEP_RST = 16'(STEP);
    localparam logic [15:0]          STEP_LIM = 16'(STEP_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [15:0]           step_q, step_d, pval_q, pval_d;
    logic                  pend_q, pend_d, cerr_q, cerr_d;
    logic                  hs_prev_q, hs_prev_d;
    logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]  ref_w_q, ref_w_d, last_w_q, last_w_d;
    logic [CNT_WIDTH-1:0]  in_w_q, in_w_d, in_h_q, in_h_d, frame_q, frame_d;
    logic                  lerr_q, lerr_d;

    logic apply, frame_end, fwd, wr_ok, hs_rise, lerr_set;

    always_comb begin
        state_d   = state_q;
        apply     = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_SYNC:   if (vs_i) state_d = S_BLANK;
            S_BLANK:  if (!vs_i) begin
                          state_d = S_ACTIVE;
                          apply   = 1'b1;
                      end
            S_ACTIVE: if (vs_i) begin
                          state_d   = S_BLANK;
                          frame_end = 1'b1;
                      end
            default:  state_d = S_SYNC;
        endcase
    end

    // Outside S_SYNC the stream passes with one register stage; otherwise it idles in blanking.
    always_comb begin
        fwd  = (state_q != S_SYNC);
        do_d = fwd ? di_i : '0;
        de_d = fwd ? de_i : 1'b0;
        hs_d = fwd ? hs_i : 1'b1;
        vs_d = fwd ? vs_i : 1'b1;
    end

    // cfg_wr_i is a single-cycle strobe sampled with cfg_step_i; there is no back-pressure.
    // A write on the apply edge lands after the apply, so it waits for the next frame.
    always_comb begin
        step_d = step_q;
        pend_d = pend_q;
        pval_d = pval_q;
        cerr_d = 1'b0;
        wr_ok  = cfg_wr_i && (cfg_step_i != 16'd0) && (cfg_step_i <= STEP_LIM);
        if (apply && pend_q) begin
            step_d = pval_q;
            pend_d = 1'b0;
        end
        if (wr_ok) begin
            pval_d = cfg_step_i;
            pend_d = 1'b1;
        end else if (cfg_wr_i) begin
            cerr_d = 1'b1;
        end
    end

    always_comb begin
        hs_prev_d  = hs_i;
        hs_rise    = hs_i && !hs_prev_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        ref_w_d    = ref_w_q;
        last_w_d   = last_w_q;
        in_w_d     = in_w_q;
        in_h_d     = in_h_q;
        frame_d    = frame_q;
        lerr_set   = 1'b0;

        if (hs_rise)
            pix_cnt_d = '0;
        else if (de_i && (pix_cnt_q != CNT_MAX))
            pix_cnt_d = pix_cnt_q + CNT_ONE;

        if ((state_q == S_ACTIVE) && hs_rise && (pix_cnt_q != '0)) begin
            if (line_cnt_q != CNT_MAX)
                line_cnt_d = line_cnt_q + CNT_ONE;
            last_w_d = pix_cnt_q;
            if (line_cnt_q == '0)
                ref_w_d = pix_cnt_q;
            else if (pix_cnt_q != ref_w_q)
                lerr_set = 1'b1;
        end

        // Uses the _d values so a line closing on the frame-end cycle still counts.
        if (frame_end) begin
            in_w_d     = last_w_d;
            in_h_d     = line_cnt_d;
            frame_d    = frame_q + CNT_ONE;
            line_cnt_d = '0;
        end else if (state_q == S_SYNC) begin
            line_cnt_d = '0;
        end

        lerr_d = err_clr_i ? 1'b0 : (lerr_q | lerr_set);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_SYNC;
            do_q       <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            step_q     <= STEP_RST;
            pval_q     <= '0;
            pend_q     <= 1'b0;
            cerr_q     <= 1'b0;
            hs_prev_q  <= 1'b1;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            ref_w_q    <= '0;
            last_w_q   <= '0;
            in_w_q     <= '0;
            in_h_q     <= '0;
            frame_q    <= '0;
            lerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            do_q       <= do_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            step_q     <= step_d;
            pval_q     <= pval_d;
            pend_q     <= pend_d;
            cerr_q     <= cerr_d;
            hs_prev_q  <= hs_prev_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            ref_w_q    <= ref_w_d;
            last_w_q   <= last_w_d;
            in_w_q     <= in_w_d;
            in_h_q     <= in_h_d;
            frame_q    <= frame_d;
            lerr_q     <= lerr_d;
        end
    end

    assign do_o         = do_q;
    assign de_o         = de_q;
    assign hs_o         = hs_q;
    assign vs_o         = vs_q;
    assign scale_step_o = step_q;
    assign cfg_pend_o   = pend_q;
    assign cfg_err_o    = cerr_q;
    assign in_w_o       = in_w_q;
    assign in_h_o       = in_h_q;
    assign frame_cnt_o  = frame_q;
    assign line_err_o   = lerr_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Directed bench for scaler_frame_ctrl: small frames, hand-computed geometry and step values.
module tb_scaler_frame_ctrl;

    localparam int W = 24;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_step_i = '0;
    logic        cfg_wr_i = 1'b0;
    logic        cfg_pend_o, cfg_err_o;
    logic        err_clr_i = 1'b0;
    logic [7:0]  di_i = '0;
    logic        de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b1;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o;
    logic [15:0] scale_step_o;
    logic [15:0] in_w_o, in_h_o, frame_cnt_o;
    logic        line_err_o;
    logic [1:0]  dbg_state_o;

    scaler_frame_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_step_i(cfg_step_i), .cfg_wr_i(cfg_wr_i),
        .cfg_pend_o(cfg_pend_o), .cfg_err_o(cfg_err_o), .err_clr_i(err_clr_i),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .scale_step_o(scale_step_o), .in_w_o(in_w_o), .in_h_o(in_h_o),
        .frame_cnt_o(frame_cnt_o), .line_err_o(line_err_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          de_out_cnt = 0;
    int          err_pulses = 0;
    bit          first_seen = 1'b0;
    logic [15:0] first_step = '0;
    logic [15:0] first_prev = '0;
    logic [15:0] prev_step = '0;
    bit          wr_req = 1'b0;
    logic [15:0] wr_val = '0;
    logic [7:0]  pix_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (de_o) begin
            de_out_cnt++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_step = scale_step_o;
                first_prev = prev_step;
            end
        end
        if (cfg_err_o) err_pulses++;
        prev_step = scale_step_o;
    endtask

    task automatic drv(input logic de, input logic hs, input logic vs);
        de_i       = de;
        hs_i       = hs;
        vs_i       = vs;
        di_i       = de ? pix_val : 8'd0;
        pix_val    = pix_val + 8'd1;
        cfg_wr_i   = wr_req;
        cfg_step_i = wr_val;
        tick();
        cfg_wr_i   = 1'b0;
        wr_req     = 1'b0;
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b1, 1'b1);
    endtask

    task automatic cfg_write(input logic [15:0] v);
        wr_req = 1'b1;
        wr_val = v;
        drv(1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_line(input int n_de);
        for (int i = 0; i < n_de; i++) drv(1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 1'b0);
    endtask

    // wr_ln = -2 writes on the first vs-low cycle (the apply edge); stop_ln aborts mid-line.
    task automatic send_frame(input int short_ln, input int wr_ln,
                              input logic [15:0] wv, input int stop_ln);
        vblank(4);
        first_seen = 1'b0;
        if (wr_ln == -2) begin
            wr_req = 1'b1;
            wr_val = wv;
        end
        drv(1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0);
        for (int l = 0; l < H; l++) begin
            if (l == stop_ln) begin
                for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, 1'b0);
                return;
            end
            if (l == wr_ln) begin
                wr_req = 1'b1;
                wr_val = wv;
            end
            send_line((l == short_ln) ? W - 1 : W);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with idle vertical blanking on the inputs
        tick(); tick();
        check("rst_do", do_o, 0);
        check("rst_de", de_o, 0);
        check("rst_hs", hs_o, 1);
        check("rst_vs", vs_o, 1);
        check("rst_step", scale_step_o, 4096);
        check("rst_pend", cfg_pend_o, 0);
        check("rst_cerr", cfg_err_o, 0);
        check("rst_in_w", in_w_o, 0);
        check("rst_in_h", in_h_o, 0);
        check("rst_frames", frame_cnt_o, 0);
        check("rst_lerr", line_err_o, 0);
        check("rst_state", dbg_state_o, 0);
        rst = 1'b0;

        // Two clean frames
        de_out_cnt = 0;
        send_frame(-1, -1, 16'd0, -1);
        check("f1_forwarded", de_out_cnt, W * H);
        send_frame(-1, -1, 16'd0, -1);
        vblank(4);
        check("t1_in_w", in_w_o, W);
        check("t1_in_h", in_h_o, H);
        check("t1_frames", frame_cnt_o, 2);
        check("t1_lerr", line_err_o, 0);
        check("t1_step", scale_step_o, 4096);

        // Reset in the middle of a frame that also has a step pending
        send_frame(-1, 1, 16'd5000, H / 2);
        check("t2_pend_before", cfg_pend_o, 1);
        rst = 1'b1;
        #1;
        check("t2_async_de", de_o, 0);
        check("t2_async_hs", hs_o, 1);
        check("t2_async_pend", cfg_pend_o, 0);
        check("t2_async_frames", frame_cnt_o, 0);
        check("t2_async_step", scale_step_o, 4096);
        tick(); tick();
        rst = 1'b0;
        de_out_cnt = 0;
        for (int l = H / 2; l < H; l++) send_line(W);
        check("t2_dropped_de", de_out_cnt, 0);
        check("t2_state_sync", dbg_state_o, 0);
        send_frame(-1, -1, 16'd0, -1);
        vblank(4);
        check("t2_in_h", in_h_o, H);
        check("t2_in_w", in_w_o, W);
        check("t2_frames", frame_cnt_o, 1);
        check("t2_de_count", de_out_cnt, W * H);
        check("t2_step_lost", first_step, 4096);

        // Mid-frame write waits for the next frame start
        send_frame(-1, 3, 16'd3686, -1);
        vblank(4);
        check("t3_pend_held", cfg_pend_o, 1);
        check("t3_step_held", scale_step_o, 4096);
        send_frame(-1, -1, 16'd0, -1);
        check("t3_first_de_step", first_step, 3686);
        check("t3_step_before_de", first_prev, 3686);
        check("t3_pend_clear", cfg_pend_o, 0);
        vblank(4);

        // Out-of-range writes
        err_pulses = 0;
        cfg_write(16'd0);
        check("t4_err_zero", cfg_err_o, 1);
        cfg_write(16'd20000);
        vblank(1);
        check("t4_err_low", cfg_err_o, 0);
        check("t4_err_pulses", err_pulses, 2);
        check("t4_pend", cfg_pend_o, 0);
        check("t4_step", scale_step_o, 3686);
        cfg_write(16'd16384);
        cfg_write(16'd16383);
        vblank(1);
        check("t4_max_ok_pend", cfg_pend_o, 1);
        check("t4_err_pulses2", err_pulses, 3);
        check("t4_step_still", scale_step_o, 3686);

        // Last write wins, then a write on the apply edge
        cfg_write(16'd3686);
        send_frame(-1, -2, 16'd5120, -1);
        check("t5_applied", first_step, 3686);
        check("t5_pend_kept", cfg_pend_o, 1);
        vblank(4);
        send_frame(-1, -1, 16'd0, -1);
        check("t5_applied_next", first_step, 5120);
        check("t5_pend_clear", cfg_pend_o, 0);
        vblank(4);

        // One short line, sticky error, then clear
        send_frame(2, -1, 16'd0, -1);
        vblank(4);
        check("t6_lerr_set", line_err_o, 1);
        check("t6_in_w", in_w_o, W);
        send_frame(-1, -1, 16'd0, -1);
        vblank(4);
        check("t6_lerr_sticky", line_err_o, 1);
        check("t6_frames", frame_cnt_o, 7);
        err_clr_i = 1'b1;
        drv(1'b0, 1'b1, 1'b1);
        err_clr_i = 1'b0;
        check("t6_lerr_clear", line_err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
